// File: rtl/n64_flashram_pkg.sv
// Shared types and constants for the N64 FlashRAM operation controller.
package n64_flashram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE,
        S_RELEASE
    } e_flashram_ctrl_state;

    localparam int unsigned PAGE_WORDS    = 32;
    localparam int unsigned SECTOR_WORDS  = 4096;
    localparam int unsigned CHIP_WORDS    = 32768;
    localparam int unsigned WORD_IDX_W    = 15;
    localparam logic [31:0] ERASE_PATTERN = 32'hFFFF_FFFF;

    // Byte address of a FlashRAM word inside the memory image.
    function automatic logic [31:0] word_byte_address(input logic [31:0]           base,
                                                      input logic [WORD_IDX_W-1:0] word_idx);
        return base + {15'd0, word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/n64_flashram_controller.sv
// Executes FlashRAM page writes and sector/chip erases as word writes into SDRAM.
module n64_flashram_controller
    import n64_flashram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h03FE_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flashram_operation_pending,
    input  logic        flashram_write_or_erase,
    input  logic        flashram_sector_or_all,
    input  logic [9:0]  flashram_sector,
    output logic [4:0]  flashram_address,
    input  logic [31:0] flashram_rdata,
    output logic        flashram_operation_done,
    output logic        mem_request,
    input  logic        mem_ack,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata
);

    e_flashram_ctrl_state state_q, state_d;
    logic [WORD_IDX_W-1:0] counter_q, counter_d;
    logic [WORD_IDX_W-1:0] start_q, start_d;
    logic [WORD_IDX_W-1:0] last_q, last_d;
    logic                  is_write_q, is_write_d;
    logic                  fetch_wait_q, fetch_wait_d;
    logic                  mem_request_q, mem_request_d;
    logic                  mem_write_q, mem_write_d;
    logic [31:0]           mem_address_q, mem_address_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [4:0]            fr_address_q, fr_address_d;
    logic                  done_q, done_d;

    logic [WORD_IDX_W-1:0] start_c;
    logic [WORD_IDX_W-1:0] last_c;
    logic [WORD_IDX_W-1:0] word_idx_c;
    logic [WORD_IDX_W-1:0] next_counter_c;

    // Decode first word and last counter value of the requested operation.
    always_comb begin
        start_c = '0;
        last_c  = WORD_IDX_W'(PAGE_WORDS - 1);
        if (!flashram_write_or_erase) begin
            start_c = {flashram_sector, 5'd0};
            last_c  = WORD_IDX_W'(PAGE_WORDS - 1);
        end else if (flashram_sector_or_all) begin
            start_c = '0;
            last_c  = WORD_IDX_W'(CHIP_WORDS - 1);
        end else begin
            start_c = {flashram_sector[9:7], 12'd0};
            last_c  = WORD_IDX_W'(SECTOR_WORDS - 1);
        end
    end

    assign word_idx_c     = start_q + counter_q;
    assign next_counter_c = counter_q + WORD_IDX_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        start_d       = start_q;
        last_d        = last_q;
        is_write_d    = is_write_q;
        fetch_wait_d  = fetch_wait_q;
        mem_request_d = mem_request_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        fr_address_d  = fr_address_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flashram_operation_pending) begin
                    counter_d  = '0;
                    start_d    = start_c;
                    last_d     = last_c;
                    is_write_d = !flashram_write_or_erase;
                    if (!flashram_write_or_erase) begin
                        fr_address_d = 5'd0;
                        fetch_wait_d = 1'b1;
                        state_d      = S_FETCH;
                    end else begin
                        mem_wdata_d   = ERASE_PATTERN;
                        mem_address_d = word_byte_address(BASE_ADDRESS, start_c);
                        mem_request_d = 1'b1;
                        state_d       = S_WRITE;
                    end
                end
            end
            S_FETCH: begin
                // Page buffer read data arrives one cycle after the address.
                if (fetch_wait_q) begin
                    fetch_wait_d = 1'b0;
                end else begin
                    mem_wdata_d   = flashram_rdata;
                    mem_address_d = word_byte_address(BASE_ADDRESS, word_idx_c);
                    mem_request_d = 1'b1;
                    state_d       = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!mem_request_q) begin
                    // Erase re-raises the request after the mandatory idle cycle.
                    mem_address_d = word_byte_address(BASE_ADDRESS, word_idx_c);
                    mem_request_d = 1'b1;
                end else if (mem_ack) begin
                    mem_request_d = 1'b0;
                    if (counter_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        counter_d = next_counter_c;
                        if (is_write_q) begin
                            fr_address_d = next_counter_c[4:0];
                            fetch_wait_d = 1'b1;
                            state_d      = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Pending drops a cycle after done; wait so it cannot retrigger.
                if (!flashram_operation_pending) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mem_write_d = mem_request_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            counter_q     <= '0;
            start_q       <= '0;
            last_q        <= '0;
            is_write_q    <= 1'b0;
            fetch_wait_q  <= 1'b0;
            mem_request_q <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            fr_address_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            start_q       <= start_d;
            last_q        <= last_d;
            is_write_q    <= is_write_d;
            fetch_wait_q  <= fetch_wait_d;
            mem_request_q <= mem_request_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            fr_address_q  <= fr_address_d;
            done_q        <= done_d;
        end
    end

    assign flashram_address        = fr_address_q;
    assign flashram_operation_done = done_q;
    assign mem_request             = mem_request_q;
    assign mem_write               = mem_write_q;
    assign mem_address             = mem_address_q;
    assign mem_wdata               = mem_wdata_q;

endmodule

// File: tb/tb_n64_flashram_controller.sv
// Directed bench for the FlashRAM controller: operation table plus reset/retrigger sequences.
module tb_n64_flashram_controller;

    localparam logic [31:0] BASE = 32'h03FE_0000;

    typedef struct {
        logic        erase;
        logic        all;
        logic [9:0]  sec;
        int          delay;
        logic [31:0] addr0;
        int          count;
        logic [31:0] data_base;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        pending;
    logic        woe;
    logic        soa;
    logic [9:0]  sector;
    logic [4:0]  fr_addr;
    logic [31:0] rdata;
    logic        done;
    logic        mem_request;
    logic        mem_ack;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;

    logic [31:0] page_buf [32];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // Page buffer model with one cycle of read latency.
    always @(posedge clk) rdata <= page_buf[fr_addr];

    n64_flashram_controller #(.BASE_ADDRESS(BASE)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .flashram_operation_pending (pending),
        .flashram_write_or_erase    (woe),
        .flashram_sector_or_all     (soa),
        .flashram_sector            (sector),
        .flashram_address           (fr_addr),
        .flashram_rdata             (rdata),
        .flashram_operation_done    (done),
        .mem_request                (mem_request),
        .mem_ack                    (mem_ack),
        .mem_write                  (mem_write),
        .mem_address                (mem_address),
        .mem_wdata                  (mem_wdata)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one operation, acting as the SDRAM slave and scoreboarding every write.
    task automatic run_op(input vec_t v, input int abort_at);
        int          idx;
        int          stall;
        int          n_done;
        int          cyc;
        int          limit;
        logic        prev_ack;
        logic [31:0] exp_data;
        idx      = 0;
        stall    = 0;
        n_done   = 0;
        cyc      = 0;
        prev_ack = 1'b0;
        limit    = v.count * (v.delay + 4) + 64;
        for (int i = 0; i < 32; i++) page_buf[i] = v.data_base + 32'(i);
        pending = 1'b1;
        woe     = v.erase;
        soa     = v.all;
        sector  = v.sec;
        tick();
        // Scramble inputs once the operation has been latched.
        woe    = ~v.erase;
        soa    = ~v.all;
        sector = ~v.sec;
        while (n_done == 0 && cyc < limit) begin
            mem_ack = 1'b0;
            if (prev_ack) check("req_gap", 96'(mem_request), 96'(0));
            prev_ack = 1'b0;
            if (done) begin
                n_done++;
                check("done_after_last_ack", 96'(idx), 96'(v.count));
            end else if (mem_request) begin
                if (idx >= v.count) begin
                    check("extra_request", 96'(idx), 96'(v.count - 1));
                end
                exp_data = v.erase ? 32'hFFFF_FFFF : v.data_base + 32'(idx);
                check(stall == 0 ? "word" : "word_stall",
                      {31'd0, mem_write, mem_address, mem_wdata},
                      {32'd1, v.addr0 + 32'(idx * 4), exp_data});
                if (idx == abort_at && stall == 0) begin
                    reset = 1'b1;
                    tick();
                    check("reset_clears",
                          {24'd0, mem_request, mem_write, done, fr_addr, mem_address, mem_wdata},
                          96'(0));
                    reset   = 1'b0;
                    pending = 1'b0;
                    for (int k = 0; k < 4; k++) begin
                        tick();
                        check("no_done_after_reset", {94'd0, mem_request, done}, 96'(0));
                    end
                    return;
                end
                if (stall == v.delay) begin
                    mem_ack  = 1'b1;
                    prev_ack = 1'b1;
                    idx++;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
            tick();
            cyc++;
        end
        mem_ack = 1'b0;
        if (n_done == 0) check("op_timeout", 96'(cyc), 96'(0));
        check("write_count", 96'(idx), 96'(v.count));
        for (int k = 0; k < v.hold; k++) begin
            tick();
            check("no_retrigger", {94'd0, mem_request, done}, 96'(0));
        end
        pending = 1'b0;
        tick();
        tick();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 10'h005, 0, 32'h03FE_0280, 32,    32'hA500_0000, 3};
        vecs[1] = '{1'b0, 1'b0, 10'h000, 7, 32'h03FE_0000, 32,    32'h5A00_0000, 0};
        vecs[2] = '{1'b1, 1'b0, 10'h085, 0, 32'h03FE_4000, 4096,  32'h0,         0};
        vecs[3] = '{1'b0, 1'b0, 10'h3FF, 2, 32'h03FF_FF80, 32,    32'hC300_0000, 0};
        vecs[4] = '{1'b1, 1'b1, 10'h3FF, 0, 32'h03FE_0000, 32768, 32'h0,         0};

        reset   = 1'b1;
        pending = 1'b0;
        woe     = 1'b0;
        soa     = 1'b0;
        sector  = '0;
        mem_ack = 1'b0;
        for (int i = 0; i < 32; i++) page_buf[i] = '0;
        repeat (3) tick();
        check("reset_state",
              {24'd0, mem_request, mem_write, done, fr_addr, mem_address, mem_wdata}, 96'(0));
        reset = 1'b0;

        // Stray acks while idle must not start anything.
        mem_ack = 1'b1;
        tick();
        tick();
        check("idle_ack_ignored", {94'd0, mem_request, done}, 96'(0));
        mem_ack = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_op(vecs[i], -1);

        // Reset in the middle of a sector erase, then a normal page write.
        run_op('{1'b1, 1'b0, 10'h085, 0, 32'h03FE_4000, 4096, 32'h0, 0}, 100);
        tick();
        run_op('{1'b0, 1'b0, 10'h001, 1, 32'h03FE_0080, 32, 32'h1234_0000, 0}, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/n64_flashram_controller.md
Name: n64_flashram_controller

Overview:
- Executes the write-page and erase operations that the N64 FlashRAM command front-end posts via `flashram.operation_pending`.
- Write: copies the 32-word page buffer into FlashRAM backing memory. Erase: fills a 16 KiB sector or the whole 128 KiB chip with 32'hFFFF_FFFF.
- Sits between the FlashRAM command front-end (if_flashram, controller side) and a word-wide memory master port into SDRAM.
- Completion is signalled with a single-cycle `operation_done`.

Parameters:
- BASE_ADDRESS, 32'h03FE_0000, byte address of FlashRAM image in memory; must be 128 KiB aligned.

Ports:
- sys.clk  in  1  system clock (if_system).
- sys.reset  in  1  synchronous, active-high reset (if_system).
- flashram.operation_pending  in  1  level; operation requested, held until after operation_done.
- flashram.write_or_erase  in  1  0 = write page, 1 = erase.
- flashram.sector_or_all  in  1  erase scope: 0 = sector, 1 = chip.
- flashram.sector  in  10  page number (128 B pages).
- flashram.address  out  5  page-buffer word index.
- flashram.rdata  in  32  page-buffer word; valid 1 cycle after address.
- flashram.operation_done  out  1  one-cycle completion pulse.
- mem_request  out  1  memory write request.
- mem_ack  in  1  one-cycle acceptance of current request.
- mem_write  out  1  always 1 while mem_request is high.
- mem_address  out  32  word-aligned byte address.
- mem_wdata  out  32  write data.

Behaviour:
- Reset values: mem_request=0, mem_write=0, mem_address=0, mem_wdata=0, flashram.address=0, operation_done=0, state=S_IDLE, word counter=0.
- Operation is sampled in S_IDLE when operation_pending=1. Inputs write_or_erase, sector_or_all and sector are latched on that cycle.
- Start word:
  - write: sector*32
  - sector erase: {sector[9:7],7'd0}*32
  - chip erase: 0
- Word count: write 32, sector erase 4096, chip erase 32768. Counter is 15 bits and counts up from 0.
- mem_address = BASE_ADDRESS + ((start_word + counter) << 2). Computed in 32 bits; no wrap beyond the 128 KiB window.
- States:
  - S_IDLE -> (pending & write) S_FETCH; (pending & erase) S_WRITE with mem_wdata=FFFF_FFFF.
  - S_FETCH: drive flashram.address=counter[4:0], wait 1 cycle; latch rdata into mem_wdata; -> S_WRITE.
  - S_WRITE: mem_request=1. address and wdata are stable until mem_ack. On mem_ack: mem_request=0 next cycle, then:
    - if last word -> S_DONE;
    - else counter+1, and -> S_FETCH (write) or stay in S_WRITE (erase).
  - S_DONE: operation_done=1 for exactly one cycle -> S_RELEASE.
  - S_RELEASE: wait for operation_pending=0 -> S_IDLE. This blocks a retrigger from the one-cycle lag before pending falls.
- mem_request deasserts for at least one cycle between words. An ack that arrives the same cycle request rises is legal.
- An ack seen while mem_request=0 is ignored.
- Minimum latency per word: write 3 cycles, erase 2 cycles, each with ack in the first request cycle.
- Reset mid-operation: all outputs return to reset values next cycle; no done pulse is issued and memory writes stop immediately.
- Input changes while busy are ignored; only the values latched in S_IDLE are used.

Decomposition:
- Package `n64_flashram_pkg` holds:
  - e_flashram_ctrl_state (S_IDLE, S_FETCH, S_WRITE, S_DONE, S_RELEASE)
  - constants PAGE_WORDS=32, SECTOR_WORDS=4096, CHIP_WORDS=32768, ERASE_PATTERN=32'hFFFF_FFFF.
- Single module, no sub-module; the address generator is a few assignments and stays inline.

Test Plan:
- Write page 5, buffer word i = 32'hA500_0000+i, ack every request immediately -> exactly 32 writes to BASE+0x280..BASE+0x2FC with data A5000000..A500001F, then one done pulse.
- Sector erase, sector=10'h085 -> 4096 writes of FFFF_FFFF covering BASE+0x4000..BASE+0x7FFC in order, then one done pulse.
- Chip erase, sector=10'h3FF -> 32768 writes of FFFF_FFFF from BASE to BASE+0x1FFFC, then done.
- Write page 0 with ack delayed 7 cycles per word -> mem_address/mem_wdata/mem_request constant throughout each stall; total 32 acks; done only after the last ack.
- Pulse sys.reset during erase word 100 -> mem_request=0 next cycle, no done pulse. A subsequent write of page 1 completes normally at BASE+0x80..BASE+0xFC.
- Keep operation_pending high 3 cycles after done -> no second operation starts. Pending low then high again -> a new operation starts.
